sauria_cfg_reg2axil: RTL and testbench

- Bridges Cheshire's external register-bus slave port (region 0, 0x4000_0000–0x44FF_FFFF) onto SAURIA's AXI4-Lite configuration slave.
- Window-checks and rebases each register access, converts it into one AXI-Lite transaction, and returns the result as a single-cycle regbus response.
- A timeout guards against a hung accelerator.
- Sits between the Cheshire regbus demux output and the SAURIA config port.

---
 rtl/sauria_cfg_reg2axil.sv | 194 +++++++++++++++++++
 tb/tb_sauria_cfg_reg2axil.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sauria_cfg_reg2axil.sv
// Cheshire regbus to SAURIA AXI4-Lite configuration bridge.
// One access at a time: window check, rebase, single AXI-Lite transfer, timeout.
module sauria_cfg_reg2axil #(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          OutAddrWidth  = 32,
    parameter logic [AddrWidth-1:0] WinBase       = 'h4000_0000,
    parameter logic [AddrWidth-1:0] WinEnd        = 'h4500_0000,
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [AddrWidth-1:0]    reg_addr_i,
    input  logic [DataWidth-1:0]    reg_wdata_i,
    input  logic [DataWidth/8-1:0]  reg_wstrb_i,
    output logic                    reg_ready_o,
    output logic [DataWidth-1:0]    reg_rdata_o,
    output logic                    reg_error_o,
    output logic [OutAddrWidth-1:0] aw_addr_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [DataWidth-1:0]    w_data_o,
    output logic [DataWidth/8-1:0]  w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              b_resp_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic [OutAddrWidth-1:0] ar_addr_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    input  logic [DataWidth-1:0]    r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    output logic                    busy_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN
    } state_e;

    state_e state, state_next;

    logic [OutAddrWidth-1:0] addr_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [DataWidth/8-1:0]  wstrb_q;
    logic [DataWidth-1:0]    rdata_q;
    logic                    error_q;
    logic                    timed_out;
    logic [CntWidth-1:0]     cnt;

    // Per-channel outstanding flags; they outlive a timeout so DRAIN can finish.
    logic aw_pend, w_pend, ar_pend, b_pend, r_pend;

    logic in_window, timed_state, expired, timeout;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_done;
    logic [OutAddrWidth-1:0] offset;

    assign in_window = (reg_addr_i >= WinBase) && (reg_addr_i < WinEnd)
                       && (reg_addr_i[1:0] == 2'b00);
    assign offset    = reg_addr_i[OutAddrWidth-1:0] - WinBase[OutAddrWidth-1:0];

    assign aw_hs   = aw_pend & aw_ready_i;
    assign w_hs    = w_pend & w_ready_i;
    assign ar_hs   = ar_pend & ar_ready_i;
    assign b_hs    = b_ready_o & b_valid_i;
    assign r_hs    = r_ready_o & r_valid_i;
    assign wr_done = (~aw_pend | aw_ready_i) & (~w_pend | w_ready_i);

    assign timed_state = (state == WR_REQ) || (state == WR_RESP)
                         || (state == RD_REQ) || (state == RD_RESP);
    assign expired = (cnt == CntWidth'(TimeoutCycles - 1));
    assign timeout = expired & (((state == WR_REQ) & ~wr_done)
                              | ((state == WR_RESP) & ~b_hs)
                              | ((state == RD_REQ) & ~ar_hs)
                              | ((state == RD_RESP) & ~r_hs));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (reg_valid_i) begin
                    if (!in_window) state_next = RESP;
                    else if (reg_write_i) state_next = WR_REQ;
                    else state_next = RD_REQ;
                end
            end
            WR_REQ:  if (wr_done) state_next = WR_RESP;
                     else if (timeout) state_next = RESP;
            WR_RESP: if (b_hs || timeout) state_next = RESP;
            RD_REQ:  if (ar_hs) state_next = RD_RESP;
                     else if (timeout) state_next = RESP;
            RD_RESP: if (r_hs || timeout) state_next = RESP;
            RESP:    state_next = timed_out ? DRAIN : IDLE;
            DRAIN:   if (!(aw_pend || w_pend || ar_pend || b_pend || r_pend))
                         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        reg_ready_o = (state == RESP);
        reg_rdata_o = reg_ready_o ? rdata_q : '0;
        reg_error_o = reg_ready_o & error_q;
        busy_o      = (state != IDLE);
        aw_addr_o   = addr_q;
        ar_addr_o   = addr_q;
        w_data_o    = wdata_q;
        w_strb_o    = wstrb_q;
        aw_valid_o  = aw_pend;
        w_valid_o   = w_pend;
        ar_valid_o  = ar_pend;
        b_ready_o   = b_pend && ((state == WR_RESP) || (state == RESP)
                                 || (state == DRAIN));
        r_ready_o   = r_pend && ((state == RD_RESP) || (state == RESP)
                                 || (state == DRAIN));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timed_out <= 1'b0;
            cnt       <= '0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            ar_pend   <= 1'b0;
            b_pend    <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (aw_hs) aw_pend <= 1'b0;
            if (w_hs)  w_pend  <= 1'b0;
            if (ar_hs) ar_pend <= 1'b0;
            if (b_hs)  b_pend  <= 1'b0;
            if (r_hs)  r_pend  <= 1'b0;

            if (state_next != state) cnt <= '0;
            else if (timed_state) cnt <= cnt + CntWidth'(1);

            unique case (state)
                IDLE: begin
                    if (reg_valid_i) begin
                        addr_q    <= offset;
                        wdata_q   <= reg_wdata_i;
                        wstrb_q   <= reg_wstrb_i;
                        rdata_q   <= '0;
                        error_q   <= ~in_window;
                        timed_out <= 1'b0;
                        if (in_window && reg_write_i) begin
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            b_pend  <= 1'b1;
                        end else if (in_window) begin
                            ar_pend <= 1'b1;
                            r_pend  <= 1'b1;
                        end
                    end
                end
                WR_RESP: if (b_hs) error_q <= (b_resp_i != 2'b00);
                RD_RESP: begin
                    if (r_hs) begin
                        rdata_q <= r_data_i;
                        error_q <= (r_resp_i != 2'b00);
                    end
                end
                default: ;
            endcase

            // Late responses after a timeout are drained, never reported.
            if (timeout) begin
                error_q   <= 1'b1;
                rdata_q   <= '0;
                timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sauria_cfg_reg2axil.sv
// Scoreboard bench for sauria_cfg_reg2axil with a configurable AXI-Lite slave.
// Responses, AXI addresses/data and their stability are checked by a monitor.
module tb_sauria_cfg_reg2axil;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        reg_valid_i, reg_write_i;
    logic [47:0] reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_ready_o, reg_error_o;
    logic [31:0] reg_rdata_o;
    logic [31:0] aw_addr_o, ar_addr_o, w_data_o, r_data_i;
    logic [3:0]  w_strb_o;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
    logic [1:0]  b_resp_i, r_resp_i;
    logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
    logic        r_valid_i, r_ready_o, busy_o;

    sauria_cfg_reg2axil #(.TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
        .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_wstrb_i(reg_wstrb_i), .reg_ready_o(reg_ready_o),
        .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
        .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o),
        .w_ready_i(w_ready_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i),
        .b_ready_o(b_ready_o), .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o),
        .ar_ready_i(ar_ready_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    bit          no_axi = 0;

    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;
    bit          r_never = 0;

    function automatic logic [139:0] outs();
        return {reg_ready_o, reg_rdata_o, reg_error_o, aw_addr_o, aw_valid_o,
                w_data_o, w_strb_o, w_valid_o, b_ready_o, ar_addr_o,
                ar_valid_o, r_ready_o, busy_o};
    endfunction

    // AXI-Lite slave with per-channel wait states
    initial begin
        bit aw_h, w_h, ar_h, b_h, r_h, aw_got, w_got, ar_got;
        int awc, wc, arc, bc, rc;
        aw_got = 0; w_got = 0; ar_got = 0;
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_resp_i = 0; r_data_i = 0;
        forever begin
            @(negedge clk);
            aw_h = aw_valid_o & aw_ready_i;
            w_h  = w_valid_o & w_ready_i;
            ar_h = ar_valid_o & ar_ready_i;
            b_h  = b_valid_i & b_ready_o;
            r_h  = r_valid_i & r_ready_o;
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
                b_valid_i = 0; r_valid_i = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
                continue;
            end
            if (aw_h) aw_got = 1;
            if (w_h) w_got = 1;
            if (ar_h) ar_got = 1;
            if (b_h) begin b_valid_i = 0; aw_got = 0; w_got = 0; bc = 0; end
            if (r_h) begin r_valid_i = 0; ar_got = 0; rc = 0; end
            aw_ready_i = 0;
            if (aw_valid_o) begin
                if (awc >= aw_wait) begin aw_ready_i = 1; awc = 0; end
                else awc++;
            end
            w_ready_i = 0;
            if (w_valid_o) begin
                if (wc >= w_wait) begin w_ready_i = 1; wc = 0; end
                else wc++;
            end
            ar_ready_i = 0;
            if (ar_valid_o) begin
                if (arc >= ar_wait) begin ar_ready_i = 1; arc = 0; end
                else arc++;
            end
            if (aw_got && w_got && !b_valid_i) begin
                if (bc >= b_wait) begin b_valid_i = 1; b_resp_i = b_resp_cfg; end
                else bc++;
            end
            if (ar_got && !r_valid_i && !r_never) begin
                if (rc >= r_wait) begin
                    r_valid_i = 1; r_data_i = r_data_cfg; r_resp_i = r_resp_cfg;
                end else rc++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents something
    initial begin
        rsp_t        e;
        logic [31:0] ea;
        logic [35:0] ew;
        logic        p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r;
        logic [31:0] p_aw_a, p_w_d, p_ar_a;
        logic [3:0]  p_w_s;
        p_aw_v = 0; p_aw_r = 0; p_w_v = 0; p_w_r = 0; p_ar_v = 0; p_ar_r = 0;
        p_aw_a = 0; p_w_d = 0; p_ar_a = 0; p_w_s = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                p_aw_v = 0; p_w_v = 0; p_ar_v = 0;
                continue;
            end
            if (reg_ready_o) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rsp: rdata=%h err=%b cyc=%0d",
                             reg_rdata_o, reg_error_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (reg_rdata_o !== e.rdata || reg_error_o !== e.err
                        || cyc != e.at) begin
                        n_err++;
                        $display("FAIL rsp: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                                 reg_rdata_o, reg_error_o, cyc, e.rdata, e.err, e.at);
                    end
                end
            end
            if (aw_valid_o && aw_ready_i) begin
                n_vec++;
                ea = (aw_q.size() != 0) ? aw_q.pop_front() : 32'hxxxx_xxxx;
                if (aw_addr_o !== ea) begin
                    n_err++;
                    $display("FAIL aw_addr: got %h want %h", aw_addr_o, ea);
                end
            end
            if (w_valid_o && w_ready_i) begin
                n_vec++;
                ew = (w_q.size() != 0) ? w_q.pop_front() : 36'hx_xxxx_xxxx;
                if ({w_strb_o, w_data_o} !== ew) begin
                    n_err++;
                    $display("FAIL w_data: got %h/%h want %h/%h",
                             w_strb_o, w_data_o, ew[35:32], ew[31:0]);
                end
            end
            if (ar_valid_o && ar_ready_i) begin
                n_vec++;
                ea = (ar_q.size() != 0) ? ar_q.pop_front() : 32'hxxxx_xxxx;
                if (ar_addr_o !== ea) begin
                    n_err++;
                    $display("FAIL ar_addr: got %h want %h", ar_addr_o, ea);
                end
            end
            if (p_aw_v && !p_aw_r) begin
                n_vec++;
                if (!aw_valid_o || aw_addr_o !== p_aw_a) begin
                    n_err++;
                    $display("FAIL aw_stable: got v=%b a=%h want v=1 a=%h",
                             aw_valid_o, aw_addr_o, p_aw_a);
                end
            end
            if (p_w_v && !p_w_r) begin
                n_vec++;
                if (!w_valid_o || w_data_o !== p_w_d || w_strb_o !== p_w_s) begin
                    n_err++;
                    $display("FAIL w_stable: got v=%b d=%h want v=1 d=%h",
                             w_valid_o, w_data_o, p_w_d);
                end
            end
            if (p_ar_v && !p_ar_r) begin
                n_vec++;
                if (!ar_valid_o || ar_addr_o !== p_ar_a) begin
                    n_err++;
                    $display("FAIL ar_stable: got v=%b a=%h want v=1 a=%h",
                             ar_valid_o, ar_addr_o, p_ar_a);
                end
            end
            if (no_axi) begin
                n_vec++;
                if (aw_valid_o || w_valid_o || ar_valid_o) begin
                    n_err++;
                    $display("FAIL no_axi: got aw/w/ar valid=%b%b%b want 000",
                             aw_valid_o, w_valid_o, ar_valid_o);
                end
            end
            p_aw_v = aw_valid_o; p_aw_r = aw_ready_i; p_aw_a = aw_addr_o;
            p_w_v = w_valid_o; p_w_r = w_ready_i; p_w_d = w_data_o; p_w_s = w_strb_o;
            p_ar_v = ar_valid_o; p_ar_r = ar_ready_i; p_ar_a = ar_addr_o;
        end
    end

    // Issue one regbus access; lat is cycles from request to reg_ready_o.
    task automatic req(input bit wr, input logic [47:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input bit axi, input logic [31:0] off,
                       input logic [31:0] exp_rd, input bit exp_err,
                       input int lat);
        rsp_t r;
        bit   got;
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.at    = cyc + lat;
        sb_q.push_back(r);
        if (axi) begin
            if (wr) begin
                aw_q.push_back(off);
                w_q.push_back({ws, wd});
            end else begin
                ar_q.push_back(off);
            end
        end else begin
            no_axi = 1;
        end
        reg_valid_i = 1; reg_write_i = wr; reg_addr_i = addr;
        reg_wdata_i = wd; reg_wstrb_i = ws;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (reg_ready_o) begin got = 1; break; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL req_wait: addr=%h got no reg_ready_o want one", addr);
        end
        @(posedge clk);
        #1;
        reg_valid_i = 0;
        no_axi = 0;
    endtask

    initial begin
        bit got;
        reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 0;
        reg_wdata_i = 0; reg_wstrb_i = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %h want 0", outs());
        end
        @(negedge clk);
        rst_ni = 1;
        @(posedge clk);
        #1;

        req(1, 48'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h10, 32'h0, 0, 3);

        r_wait = 5; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b00;
        req(0, 48'h44FF_FFFC, 32'h0, 4'h0, 1, 32'h04FF_FFFC, 32'h1234_5678, 0, 8);
        r_wait = 0;

        req(0, 48'h4500_0000, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1);
        req(1, 48'h4000_0002, 32'h1111_2222, 4'hF, 0, 32'h0, 32'h0, 1, 1);
        req(0, 48'h3FFF_FFFC, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1);
        req(0, 48'h1_4000_0000, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1);

        aw_wait = 3; b_resp_cfg = 2'b10;
        req(1, 48'h4000_0100, 32'hA5A5_0F0F, 4'h3, 1, 32'h100, 32'h0, 1, 6);
        aw_wait = 0; b_resp_cfg = 2'b00;

        r_data_cfg = 32'hCAFE_F00D; r_resp_cfg = 2'b11;
        req(0, 48'h4000_0008, 32'h0, 4'h0, 1, 32'h8, 32'hCAFE_F00D, 1, 3);
        r_resp_cfg = 2'b00;

        r_never = 1;
        req(0, 48'h4000_0020, 32'h0, 4'h0, 1, 32'h20, 32'h0, 1, TO + 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (!busy_o) begin
                n_err++;
                $display("FAIL drain_busy: got busy=0 want 1");
            end
        end
        r_data_cfg = 32'hBAD0_BAD0;
        r_never = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy_o) begin got = 1; break; end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL drain_release: got busy=1 want 0");
        end
        @(posedge clk);
        #1;
        r_data_cfg = 32'h600D_600D;
        req(0, 48'h4000_0024, 32'h0, 4'h0, 1, 32'h24, 32'h600D_600D, 0, 3);

        b_wait = 20;
        aw_q.push_back(32'h30);
        w_q.push_back({4'hF, 32'h7777_8888});
        reg_valid_i = 1; reg_write_i = 1; reg_addr_i = 48'h4000_0030;
        reg_wdata_i = 32'h7777_8888; reg_wstrb_i = 4'hF;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_ready_o) begin got = 1; break; end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL wr_resp_reach: got b_ready=0 want 1");
        end
        @(negedge clk);
        #2;
        rst_ni = 0;
        reg_valid_i = 0;
        #1;
        n_vec++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got %h want 0", outs());
        end
        repeat (2) @(negedge clk);
        rst_ni = 1;
        b_wait = 0;
        @(posedge clk);
        #1;
        r_data_cfg = 32'h5A5A_1234;
        req(0, 48'h4000_0040, 32'h0, 4'h0, 1, 32'h40, 32'h5A5A_1234, 0, 3);

        repeat (3) @(posedge clk);
        n_vec++;
        if (sb_q.size() + aw_q.size() + w_q.size() + ar_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got rsp=%0d aw=%0d w=%0d ar=%0d want 0",
                     sb_q.size(), aw_q.size(), w_q.size(), ar_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
